// File: rtl/regfile_arb_pkg.sv
// Shared widths and the issue-stage operation record for regfile_arbiter.
package regfile_arb_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned NUM_REQ = 2;

  typedef struct packed {
    logic              valid;
    logic              owner;
    logic              we;
    logic [ADDR_W-1:0] num;
    logic [DATA_W-1:0] wdata;
  } rf_op_t;

endpackage

// File: rtl/regfile_arbiter_rr_arb2.sv
// Two-input round-robin picker; with REGFILE_ARB_LOCK_EN it also tracks an exclusive lock owner.
module rr_arb2
  import regfile_arb_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
`ifdef REGFILE_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0] lock,
`endif
  output logic [NUM_REQ-1:0] gnt
);

  logic                prio_q, prio_d;
  logic [NUM_REQ-1:0]  rr_gnt;
`ifdef REGFILE_ARB_LOCK_EN
  logic                locked_q, locked_d;
  logic                owner_q, owner_d;
`endif

  always_comb begin
    rr_gnt = '0;
    if (req[0] && (!req[1] || !prio_q)) begin
      rr_gnt[0] = 1'b1;
    end else if (req[1]) begin
      rr_gnt[1] = 1'b1;
    end
  end

  always_comb begin
    gnt    = '0;
    prio_d = prio_q;
`ifdef REGFILE_ARB_LOCK_EN
    locked_d = locked_q;
    owner_d  = owner_q;
`endif
    if (!reset) begin
`ifdef REGFILE_ARB_LOCK_EN
      if (locked_q) begin
        gnt[owner_q] = req[owner_q];
      end else begin
        gnt = rr_gnt;
      end
`else
      gnt = rr_gnt;
`endif
      // Any transfer hands preference to the other requester.
      if (|gnt) begin
        prio_d = gnt[0];
`ifdef REGFILE_ARB_LOCK_EN
        owner_d  = gnt[1];
        locked_d = lock[gnt[1]];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= 1'b0;
`ifdef REGFILE_ARB_LOCK_EN
      locked_q <= 1'b0;
      owner_q  <= 1'b0;
`endif
    end else begin
      prio_q <= prio_d;
`ifdef REGFILE_ARB_LOCK_EN
      locked_q <= locked_d;
      owner_q  <= owner_d;
`endif
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares one 8x16 register file between two requesters via round-robin grant and a one-stage
// issue register. Optional lock ports are enabled by defining REGFILE_ARB_LOCK_EN.
module regfile_arbiter #(
  parameter int unsigned DATA_W = regfile_arb_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_arb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_0,
  input  logic              req_1,
  input  logic              we_0,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] num_0,
  input  logic [ADDR_W-1:0] num_1,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_0,
  output logic              gnt_1,
  output logic              rvalid_0,
  output logic              rvalid_1,
  output logic [DATA_W-1:0] rdata_0,
  output logic [DATA_W-1:0] rdata_1,
  output logic [ADDR_W-1:0] writenum,
  output logic              write,
  output logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] readnum,
`ifdef REGFILE_ARB_LOCK_EN
  input  logic              lock_0,
  input  logic              lock_1,
`endif
  input  logic [DATA_W-1:0] data_out
);

  localparam int unsigned NumReq = regfile_arb_pkg::NUM_REQ;

  logic [NumReq-1:0]        req, gnt, xfer;
  regfile_arb_pkg::rf_op_t  op_q, op_d;
  logic [NumReq-1:0]        rvalid_q;
  logic [DATA_W-1:0]        rdata_q [NumReq];

  assign req  = {req_1, req_0};
  assign xfer = req & gnt;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .req   (req),
`ifdef REGFILE_ARB_LOCK_EN
    .lock  ({lock_1, lock_0}),
`endif
    .gnt   (gnt)
  );

  assign gnt_0 = gnt[0];
  assign gnt_1 = gnt[1];

  // Address/data fields keep their last value while idle so the register file ports hold.
  always_comb begin
    op_d       = op_q;
    op_d.valid = 1'b0;
    if (|xfer) begin
      op_d.valid = 1'b1;
      op_d.owner = xfer[1];
      if (xfer[1]) begin
        op_d.we    = we_1;
        op_d.num   = num_1;
        op_d.wdata = wdata_1;
      end else begin
        op_d.we    = we_0;
        op_d.num   = num_0;
        op_d.wdata = wdata_0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= '0;
    end else begin
      op_q <= op_d;
    end
  end

  assign writenum = op_q.num;
  assign readnum  = op_q.num;
  assign data_in  = op_q.wdata;
  assign write    = op_q.valid & op_q.we & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q   <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      rvalid_q <= '0;
      if (op_q.valid && !op_q.we) begin
        rvalid_q[op_q.owner] <= 1'b1;
        rdata_q[op_q.owner]  <= data_out;
      end
    end
  end

  assign rvalid_0 = rvalid_q[0];
  assign rvalid_1 = rvalid_q[1];
  assign rdata_0  = rdata_q[0];
  assign rdata_1  = rdata_q[1];

endmodule
